// File: rtl/mac_pkg.sv
// Shared definitions for the weight-stationary MAC processing element:
// instruction bit positions, load FSM states and saturation bound helper.
package mac_pkg;

  localparam int INST_LOAD = 0;
  localparam int INST_EXEC = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HALF  = 2'd1,
    READY = 2'd2
  } state_t;

  // Largest (upper=1) or smallest (upper=0) value of a signed field of the given width.
  function automatic logic signed [63:0] sat_bound(input int width, input logic upper);
    if (upper) begin
      return (64'sd1 <<< (width - 1)) - 64'sd1;
    end
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/mac_dual.sv
// Combinational dual-lane multiplier: two zero-extended activation halves times
// signed weights, combined as two 2-bit lanes or as one full-width activation.
module mac_dual #(
  parameter int BW      = 4,
  parameter int PSUM_BW = 16
) (
  input  logic        [BW-1:0]      i_act,
  input  logic signed [BW-1:0]      i_w0,
  input  logic signed [BW-1:0]      i_w1,
  input  logic                      i_mode,
  output logic signed [PSUM_BW-1:0] o_product
);

  localparam int HW = BW / 2;
  localparam int PW = HW + 1 + BW;

  logic signed [HW:0]        w_a_lo;
  logic signed [HW:0]        w_a_hi;
  logic signed [PW-1:0]      w_p_lo;
  logic signed [PW-1:0]      w_p_hi;
  logic signed [PSUM_BW-1:0] w_p_lo_x;
  logic signed [PSUM_BW-1:0] w_p_hi_x;

  // Activation halves are unsigned; the extra zero MSB keeps the multiply signed.
  assign w_a_lo = {1'b0, i_act[HW-1:0]};
  assign w_a_hi = {1'b0, i_act[BW-1:HW]};

  assign w_p_lo = PW'(w_a_lo) * PW'(i_w0);
  assign w_p_hi = PW'(w_a_hi) * PW'(i_w1);

  assign w_p_lo_x = PSUM_BW'(w_p_lo);
  assign w_p_hi_x = PSUM_BW'(w_p_hi);

  assign o_product = i_mode ? (w_p_lo_x + w_p_hi_x)
                            : (w_p_lo_x + (w_p_hi_x <<< HW));

endmodule

// File: rtl/mac_pe_pipe.sv
// Weight-stationary pipelined PE: loads two weights from the west, accumulates
// activation*weight into the north psum and registers the result south.
module mac_pe_pipe
  import mac_pkg::*;
#(
  parameter int BW      = 4,
  parameter int PSUM_BW = 16,
  parameter int SAT     = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic        [BW-1:0]      in_w,
  input  logic        [1:0]         inst_w,
  input  logic                      act_2b_mode,
  input  logic signed [PSUM_BW-1:0] in_n,
  output logic        [BW-1:0]      out_e,
  output logic        [1:0]         inst_e,
  output logic signed [PSUM_BW-1:0] out_s,
  output logic                      valid_s,
  output logic                      err
);

  localparam logic signed [PSUM_BW-1:0] PSUM_MAX = PSUM_BW'(sat_bound(PSUM_BW, 1'b1));
  localparam logic signed [PSUM_BW-1:0] PSUM_MIN = PSUM_BW'(sat_bound(PSUM_BW, 1'b0));

  function automatic logic signed [PSUM_BW-1:0] sat_add(
    input logic signed [PSUM_BW-1:0] a,
    input logic signed [PSUM_BW-1:0] b
  );
    logic signed [PSUM_BW:0] s;
    s = {a[PSUM_BW-1], a} + {b[PSUM_BW-1], b};
    if (s[PSUM_BW] != s[PSUM_BW-1]) begin
      return s[PSUM_BW] ? PSUM_MIN : PSUM_MAX;
    end
    return s[PSUM_BW-1:0];
  endfunction

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      w_ld_w0;
  logic                      w_ld_w1;
  logic signed [BW-1:0]      r_w0;
  logic signed [BW-1:0]      r_w1;
  logic                      r_mode;
  logic                      w_load;
  logic                      w_exec;
  logic                      w_ready;
  logic signed [PSUM_BW-1:0] w_product;
  logic signed [PSUM_BW-1:0] w_sum;

  logic        [BW-1:0]      r_out_e_p1;
  logic        [1:0]         r_inst_e_p1;
  logic signed [PSUM_BW-1:0] r_psum_p1;
  logic                      r_vld_p1;
  logic                      r_err;

  assign w_load  = inst_w[INST_LOAD];
  assign w_exec  = inst_w[INST_EXEC];
  assign w_ready = (r_state == READY);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // In 4-bit mode one load token fills both weights; in 2-bit mode two tokens are consumed.
  always_comb begin
    w_state_nxt = r_state;
    w_ld_w0     = 1'b0;
    w_ld_w1     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_load) begin
          w_ld_w0 = 1'b1;
          if (!act_2b_mode) begin
            w_ld_w1     = 1'b1;
            w_state_nxt = READY;
          end else begin
            w_state_nxt = HALF;
          end
        end
      end
      HALF: begin
        if (w_load) begin
          w_ld_w1     = 1'b1;
          w_state_nxt = READY;
        end
      end
      READY:   w_state_nxt = READY;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_w0   <= '0;
      r_w1   <= '0;
      r_mode <= 1'b0;
    end else begin
      if (w_ld_w0) begin
        r_w0   <= in_w;
        r_mode <= act_2b_mode;
      end
      if (w_ld_w1) begin
        r_w1 <= in_w;
      end
    end
  end

  mac_dual #(
    .BW      (BW),
    .PSUM_BW (PSUM_BW)
  ) u_dual (
    .i_act     (in_w),
    .i_w0      (r_w0),
    .i_w1      (r_w1),
    .i_mode    (r_mode),
    .o_product (w_product)
  );

  always_comb begin
    w_sum = in_n + w_product;
    if (SAT != 0) begin
      w_sum = sat_add(in_n, w_product);
    end
  end

  // ---- stage p1: registered east/south outputs ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_e_p1  <= '0;
      r_inst_e_p1 <= '0;
      r_psum_p1   <= '0;
      r_vld_p1    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_out_e_p1  <= in_w;
      r_inst_e_p1 <= {w_exec, w_load & w_ready};
      r_vld_p1    <= w_exec;
      if (w_exec) begin
        if (w_ready) begin
          r_psum_p1 <= w_sum;
        end else begin
          r_psum_p1 <= in_n;
          r_err     <= 1'b1;
        end
      end
    end
  end

  assign out_e   = r_out_e_p1;
  assign inst_e  = r_inst_e_p1;
  assign out_s   = r_psum_p1;
  assign valid_s = r_vld_p1;
  assign err     = r_err;

endmodule
